// File: rtl/bin_to_bcd_feed_if.sv
// Load/result bus between the binary source, the BCD converter and the seven-segment driver.
interface bin_to_bcd_feed_if;
    logic [26:0] bin_in;
    logic        load;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [31:0] number;
    logic [7:0]  AN_ON;

    modport master (
        output bin_in, load,
        input  busy, done, overflow, number, AN_ON
    );

    modport slave (
        input  bin_in, load,
        output busy, done, overflow, number, AN_ON
    );
endinterface

// File: rtl/bin_to_bcd_feed.sv
// Iterative double-dabble converter feeding the eight-digit display driver.
// Optional leading-zero blanking on AN_ON is enabled by defining LEAD_ZERO_BLANK_EN.
module bin_to_bcd_feed (
    input  logic              clk,
    input  logic              reset,
    bin_to_bcd_feed_if.slave  bus
);
    localparam int IN_W = 27;
    localparam logic [IN_W-1:0] MAX_IN = IN_W'(99_999_999);

    typedef enum logic {IDLE, CONV} state_t;

    state_t            state, next_state;
    logic [IN_W-1:0]   shift_reg;
    logic [31:0]       acc;
    logic [31:0]       acc_adj;
    logic [31+IN_W:0]  shifted;
    logic [4:0]        step_cnt;
    logic              ovf_flag;
    logic              finish;
    logic [31:0]       number_q;
    logic              overflow_q;
    logic              done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        finish     = 1'b0;
        case (state)
            IDLE: if (bus.load) next_state = CONV;
            CONV: begin
                if (ovf_flag || step_cnt == 5'd0) begin
                    finish     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Add-3 correction keeps every nibble at or below 9 once it is doubled by the shift.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 8; i++) begin
            if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    assign shifted = {acc_adj, shift_reg} << 1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg  <= '0;
            acc        <= '0;
            step_cnt   <= '0;
            ovf_flag   <= 1'b0;
            number_q   <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= finish;
            if (state == IDLE && bus.load) begin
                shift_reg <= bus.bin_in;
                acc       <= '0;
                step_cnt  <= 5'd27;
                ovf_flag  <= (bus.bin_in > MAX_IN);
            end else if (state == CONV && !finish) begin
                acc       <= shifted[31+IN_W:IN_W];
                shift_reg <= shifted[IN_W-1:0];
                step_cnt  <= step_cnt - 5'd1;
            end
            if (finish) begin
                number_q   <= ovf_flag ? 32'hEEEE_EEEE : acc;
                overflow_q <= ovf_flag;
            end
        end
    end

`ifdef LEAD_ZERO_BLANK_EN
    logic [7:0] an_on_q;
    logic [7:0] blank_mask;
    logic       zero_above;

    // Walk down from the top digit; a digit blanks only while everything above it is zero.
    always_comb begin
        blank_mask = 8'h00;
        zero_above = 1'b1;
        for (int i = 7; i >= 1; i--) begin
            zero_above    = zero_above & (acc[4*i +: 4] == 4'd0);
            blank_mask[i] = zero_above;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      an_on_q <= 8'hFE;
        else if (finish) an_on_q <= ovf_flag ? 8'h00 : blank_mask;
    end

    assign bus.AN_ON = an_on_q;
`else
    assign bus.AN_ON = 8'h00;
`endif

    assign bus.busy     = (state == CONV);
    assign bus.done     = done_q;
    assign bus.number   = number_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_bin_to_bcd_feed.sv
// Directed bench for bin_to_bcd_feed: vector table plus reset, handshake and back-to-back sequences.
module tb_bin_to_bcd_feed;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    bin_to_bcd_feed_if bus ();

    bin_to_bcd_feed dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [26:0] value;
        logic [31:0] exp_number;
        logic [7:0]  exp_blank;
        logic        exp_ovf;
        int          exp_latency;
    } vec_t;

    vec_t vectors[10];

    function automatic logic [7:0] expAnOn(input logic [7:0] blank);
`ifdef LEAD_ZERO_BLANK_EN
        return blank;
`else
        return 8'h00;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Starts one conversion and waits (bounded) for done, tracking that number holds meanwhile.
    task automatic applyStimulus(input logic [26:0] value, output int latency,
                                 output logic busy_seen, output logic stable);
        logic [31:0] held;
        @(negedge clk);
        held       = bus.number;
        bus.bin_in = value;
        bus.load   = 1'b1;
        @(posedge clk);
        #1;
        bus.load  = 1'b0;
        busy_seen = bus.busy;
        latency   = 0;
        stable    = 1'b1;
        while (bus.done !== 1'b1 && latency < 60) begin
            if (bus.number !== held) stable = 1'b0;
            @(posedge clk);
            #1;
            latency++;
        end
    endtask

    initial begin
        int          latency;
        logic        busy_seen;
        logic        stable;
        int          pulses;
        int          changes;
        logic [31:0] last;
        logic [31:0] result;
        int          first_done;
        int          second_done;

        vectors[0] = '{27'd12_345_678,  32'h1234_5678, 8'h00, 1'b0, 28};
        vectors[1] = '{27'd407,         32'h0000_0407, 8'hF8, 1'b0, 28};
        vectors[2] = '{27'd0,           32'h0000_0000, 8'hFE, 1'b0, 28};
        vectors[3] = '{27'd99_999_999,  32'h9999_9999, 8'h00, 1'b0, 28};
        vectors[4] = '{27'd100_000_000, 32'hEEEE_EEEE, 8'h00, 1'b1, 1};
        vectors[5] = '{27'd5,           32'h0000_0005, 8'hFE, 1'b0, 28};
        vectors[6] = '{27'd134_217_727, 32'hEEEE_EEEE, 8'h00, 1'b1, 1};
        vectors[7] = '{27'd10,          32'h0000_0010, 8'hFC, 1'b0, 28};
        vectors[8] = '{27'd90_000_000,  32'h9000_0000, 8'h00, 1'b0, 28};
        vectors[9] = '{27'd1000,        32'h0000_1000, 8'hF0, 1'b0, 28};

        reset      = 1'b0;
        bus.load   = 1'b0;
        bus.bin_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy",     32'(bus.busy),     32'h0);
        checkOutput("reset done",     32'(bus.done),     32'h0);
        checkOutput("reset number",   bus.number,        32'h0);
        checkOutput("reset AN_ON",    32'(bus.AN_ON),    32'(expAnOn(8'hFE)));
        checkOutput("reset overflow", 32'(bus.overflow), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vectors[i].value, latency, busy_seen, stable);
            checkOutput($sformatf("vec%0d busy after load", i), 32'(busy_seen), 32'h1);
            checkOutput($sformatf("vec%0d latency", i), 32'(latency), 32'(vectors[i].exp_latency));
            checkOutput($sformatf("vec%0d number hold", i), 32'(stable), 32'h1);
            checkOutput($sformatf("vec%0d number", i), bus.number, vectors[i].exp_number);
            checkOutput($sformatf("vec%0d AN_ON", i), 32'(bus.AN_ON), 32'(expAnOn(vectors[i].exp_blank)));
            checkOutput($sformatf("vec%0d overflow", i), 32'(bus.overflow), 32'(vectors[i].exp_ovf));
            checkOutput($sformatf("vec%0d busy at done", i), 32'(bus.busy), 32'h0);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d done width", i), 32'(bus.done), 32'h0);
        end

        // Abort a conversion ten cycles in; outputs must drop to reset values with no done.
        @(negedge clk);
        bus.bin_in = 27'd12_345_678;
        bus.load   = 1'b1;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("abort busy",     32'(bus.busy),     32'h0);
        checkOutput("abort done",     32'(bus.done),     32'h0);
        checkOutput("abort number",   bus.number,        32'h0);
        checkOutput("abort AN_ON",    32'(bus.AN_ON),    32'(expAnOn(8'hFE)));
        checkOutput("abort overflow", 32'(bus.overflow), 32'h0);
        @(negedge clk);
        reset  = 1'b1;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
        end
        checkOutput("abort no done", 32'(pulses), 32'h0);

        // A second load while busy must be dropped, not queued.
        @(negedge clk);
        bus.bin_in = 27'd5;
        bus.load   = 1'b1;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        pulses   = 0;
        changes  = 0;
        last     = bus.number;
        result   = '0;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk);
            #1;
            if (c == 12) begin
                bus.bin_in = 27'd9;
                bus.load   = 1'b1;
            end
            if (c == 13) bus.load = 1'b0;
            if (bus.done) begin
                pulses++;
                result = bus.number;
            end
            if (bus.number !== last) begin
                changes++;
                last = bus.number;
            end
        end
        checkOutput("busy load pulses",  32'(pulses),  32'h1);
        checkOutput("busy load result",  result,       32'h0000_0005);
        checkOutput("busy load changes", 32'(changes), 32'h1);

        // Held load: consecutive results arrive 29 cycles apart.
        @(negedge clk);
        bus.bin_in  = 27'd407;
        bus.load    = 1'b1;
        first_done  = -1;
        second_done = -1;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                if (first_done < 0) begin
                    first_done = c;
                end else begin
                    second_done = c;
                    bus.load    = 1'b0;
                    break;
                end
            end
        end
        bus.load = 1'b0;
        checkOutput("held load first done", 32'(first_done), 32'd29);
        checkOutput("held load period", 32'(second_done - first_done), 32'd29);
        checkOutput("held load number", bus.number, 32'h0000_0407);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("held load released idle", 32'(bus.busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
